// File: rtl/rv32i_dii_sequencer.sv
// Host-side DII sequencer: buffers host commands, feeds the core fetch port and runs the end-of-test
// drain / core-reset / halt-ack handshake. Optional DRAIN watchdog under `DII_DRAIN_TIMEOUT_EN.
module rv32i_dii_sequencer #(
  parameter int FIFO_DEPTH    = 8,
  parameter int RST_CYCLES    = 4,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dii_cmd_valid,
  output logic        dii_cmd_ready,
  input  logic [7:0]  dii_cmd,
  input  logic [31:0] dii_insn,
  input  logic        fetch_req,
  output logic        instr_valid,
  output logic [31:0] instr,
  input  logic        retire,
  output logic        core_rst_req,
  output logic        halt_valid,
  input  logic        halt_ready,
  output logic [31:0] issued_cnt,
  output logic [7:0]  outstanding,
  output logic        timeout_err
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int RCW = $clog2(RST_CYCLES + 1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_RESET, ST_HALT_ACK} state_e;

  logic        mem_cmd  [FIFO_DEPTH];
  logic [31:0] mem_insn [FIFO_DEPTH];

  logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  state_e          state_q, state_d;
  logic [RCW-1:0]  rst_cnt_q, rst_cnt_d;
  logic [31:0]     issued_q, issued_d;
  logic [7:0]      outst_q, outst_d;
  logic [31:0]     instr_q;

  logic fifo_empty, fifo_full, push, pop, issue, clear_issued, force_clear;
  logic head_cmd, head_is_insn, head_is_eot;
  logic [31:0] head_insn;

  assign fifo_empty    = (wr_ptr_q == rd_ptr_q);
  assign fifo_full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dii_cmd_ready = !fifo_full;
  // Illegal command codes are handshaken but never written.
  assign push          = dii_cmd_valid && !fifo_full && (dii_cmd == 8'd1 || dii_cmd == 8'd0);

  assign head_cmd     = mem_cmd[rd_ptr_q[AW-1:0]];
  assign head_insn    = mem_insn[rd_ptr_q[AW-1:0]];
  assign head_is_insn = !fifo_empty && head_cmd;
  assign head_is_eot  = !fifo_empty && !head_cmd;

  assign instr       = instr_valid ? head_insn : instr_q;
  assign issued_cnt  = issued_q;
  assign outstanding = outst_q;

`ifdef DII_DRAIN_TIMEOUT_EN
  localparam int DCW = $clog2(DRAIN_TIMEOUT + 1);
  logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
  logic           timeout_q, timeout_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      drain_cnt_q <= drain_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  logic unused_drain_timeout;
  assign unused_drain_timeout = ^DRAIN_TIMEOUT;
  assign timeout_err          = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    pop          = 1'b0;
    issue        = 1'b0;
    clear_issued = 1'b0;
    force_clear  = 1'b0;
    instr_valid  = 1'b0;
    core_rst_req = 1'b0;
    halt_valid   = 1'b0;
`ifdef DII_DRAIN_TIMEOUT_EN
    drain_cnt_d  = drain_cnt_q;
    timeout_d    = timeout_q;
`endif
    unique case (state_q)
      ST_RUN: begin
        if (head_is_insn) begin
          instr_valid = 1'b1;
          if (fetch_req) begin
            pop   = 1'b1;
            issue = 1'b1;
          end
        end else if (head_is_eot) begin
          pop     = 1'b1;
          state_d = ST_DRAIN;
`ifdef DII_DRAIN_TIMEOUT_EN
          drain_cnt_d = '0;
`endif
        end
      end
      ST_DRAIN: begin
        if (outst_q == 8'd0) begin
          state_d   = ST_RESET;
          rst_cnt_d = RCW'(RST_CYCLES);
        end
`ifdef DII_DRAIN_TIMEOUT_EN
        else if (drain_cnt_q == DCW'(DRAIN_TIMEOUT - 1)) begin
          state_d     = ST_RESET;
          rst_cnt_d   = RCW'(RST_CYCLES);
          force_clear = 1'b1;
          timeout_d   = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
`endif
      end
      ST_RESET: begin
        core_rst_req = 1'b1;
        if (rst_cnt_q == RCW'(1)) state_d = ST_HALT_ACK;
        else                      rst_cnt_d = rst_cnt_q - 1'b1;
      end
      ST_HALT_ACK: begin
        halt_valid = 1'b1;
        if (halt_ready) begin
          state_d      = ST_RUN;
          clear_issued = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    outst_d = outst_q;
    if (force_clear)                          outst_d = 8'd0;
    else if (issue && retire)                 outst_d = outst_q;
    else if (issue && outst_q != 8'hFF)       outst_d = outst_q + 8'd1;
    else if (!issue && retire && outst_q != 8'd0) outst_d = outst_q - 8'd1;

    issued_d = issued_q;
    if (clear_issued) issued_d = 32'd0;
    else if (issue)   issued_d = issued_q + 32'd1;

    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_cmd[wr_ptr_q[AW-1:0]]  <= dii_cmd[0];
      mem_insn[wr_ptr_q[AW-1:0]] <= dii_insn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      state_q   <= ST_RUN;
      rst_cnt_q <= '0;
      issued_q  <= 32'd0;
      outst_q   <= 8'd0;
      instr_q   <= 32'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      issued_q  <= issued_d;
      outst_q   <= outst_d;
      instr_q   <= instr;
    end
  end

endmodule
